// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, fetch FSM state encoding and
// architectural constants used by the fetch stage.
package core_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] TRAP_VEC_DEFAULT = 32'h0000_0100;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC owner: issues one outstanding instruction-memory request at a time,
// hands the returned word to decode, and applies execute-stage redirects.
//
// Handshake rule for both interfaces: a transfer happens on a rising clock edge
// where valid and ready are both high; valid never depends on ready, and the
// payload is held stable while valid is high and ready is low.
module fetch_pc_ctrl
  import core_pkg::*;
#(
  parameter int              XLEN     = core_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = core_pkg::RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] TRAP_VEC = core_pkg::TRAP_VEC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic            flush,
  output logic            misalign_trap,
  output fetch_state_e    dbg_state
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [31:0]     if_instr_q, if_instr_d;
  logic            trap_q, trap_d;

  logic req_fire;
  logic in_flight_after;

  assign req_fire = (state_q == REQ) && imem_req_ready;

  // A request is still outstanding after this edge if one was just accepted
  // or an earlier one has not yet returned its response.
  assign in_flight_after = req_fire ||
                           ((state_q == WAIT) && !imem_resp_valid) ||
                           ((state_q == DROP) && !imem_resp_valid);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    if_valid_d    = if_valid_q;
    if_pc_d       = if_pc_q;
    if_instr_d    = if_instr_q;
    trap_d        = 1'b0;

    case (state_q)
      REQ: begin
        if (imem_req_ready) begin
          inflight_pc_d = pc_q;
          pc_d          = pc_q + XLEN'(INSTR_BYTES);
          state_d       = WAIT;
        end
      end
      WAIT: begin
        if (imem_resp_valid) begin
          if_instr_d = imem_resp_data;
          if_pc_d    = inflight_pc_q;
          if_valid_d = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (if_ready) begin
          if_valid_d = 1'b0;
          state_d    = REQ;
        end
      end
      DROP: begin
        if (imem_resp_valid) begin
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase

    // Redirect overrides everything above; a same-cycle response is simply
    // not latched because the payload registers are restored here.
    if (redirect_valid) begin
      if_valid_d = 1'b0;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      if (is_misaligned(redirect_pc[1:0])) begin
        pc_d   = TRAP_VEC;
        trap_d = 1'b1;
      end else begin
        pc_d = redirect_pc;
      end
      state_d = in_flight_after ? DROP : REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= REQ;
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
      if_valid_q    <= 1'b0;
      if_pc_q       <= '0;
      if_instr_q    <= '0;
      trap_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      if_valid_q    <= if_valid_d;
      if_pc_q       <= if_pc_d;
      if_instr_q    <= if_instr_d;
      trap_q        <= trap_d;
    end
  end

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = pc_q;
  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_instr       = if_instr_q;
  assign flush          = redirect_valid;
  assign misalign_trap  = trap_q;
  assign dbg_state      = state_q;

endmodule
